// File: rtl/axi_sram_slave_if.sv
// AXI4 slave responder for a single-port synchronous SRAM macro.
// Handles one INCR burst at a time. Read beats stream one per cycle
// straight from the SRAM output, with a hold register used during back-pressure.
// Write beats go to the SRAM on the W handshake. Beats are counted to find
// the end of the burst, and WLAST is only checked against that count.
module axi_sram_slave_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                  axi_clk,
    input  logic                  axi_rstn,
    // read address channel
    input  logic [ID_W-1:0]       ARID,
    input  logic [31:0]           ARADDR,
    input  logic [LEN_W-1:0]      ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    // read data channel
    output logic [ID_W-1:0]       RID,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    // write address channel
    input  logic [ID_W-1:0]       AWID,
    input  logic [31:0]           AWADDR,
    input  logic [LEN_W-1:0]      AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    // write data channel
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    // write response channel
    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    // SRAM macro
    output logic                  sram_ceb,
    output logic [DATA_W/8-1:0]   sram_web,
    output logic [ADDR_W-1:0]     sram_a,
    output logic [DATA_W-1:0]     sram_di,
    input  logic [DATA_W-1:0]     sram_do
);

    localparam int   STRB_W  = DATA_W / 8;
    localparam int   CNT_W   = LEN_W + 1;
    localparam logic LAST_RD = 1'b0;
    localparam logic LAST_WR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_WR    = 2'd2,
        S_WRESP = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic                rr_last_q, rr_last_d;
    logic [ID_W-1:0]     id_q,      id_d;
    logic [LEN_W-1:0]    len_q,     len_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;     // next SRAM word to access
    logic [CNT_W-1:0]    cnt_q,     cnt_d;      // beat index within the burst
    logic                rvalid_q,  rvalid_d;
    logic                fresh_q,   fresh_d;    // SRAM output holds the current beat
    logic [DATA_W-1:0]   hold_q,    hold_d;
    logic                err_q,     err_d;
    logic                bvalid_q,  bvalid_d;

    logic                ar_rdy, aw_rdy, w_rdy;
    logic                ceb;
    logic [STRB_W-1:0]   web;
    logic [ADDR_W-1:0]   a;
    logic [DATA_W-1:0]   di;
    logic                beat_last;
    logic                grant_r, grant_w;
    logic [ADDR_W-1:0]   ar_word, aw_word;

    // Size/burst fields and the address bits outside the word index are not needed.
    logic unused_fields;
    assign unused_fields = ^{ARSIZE, ARBURST, AWSIZE, AWBURST,
                             ARADDR[31:ADDR_W+2], ARADDR[1:0],
                             AWADDR[31:ADDR_W+2], AWADDR[1:0]};

    assign ar_word   = ARADDR[ADDR_W+1:2];
    assign aw_word   = AWADDR[ADDR_W+1:2];
    assign beat_last = (cnt_q == {1'b0, len_q});

    // When both address channels request at once, serve the one not accepted last time.
    assign grant_w = AWVALID && (!ARVALID || (rr_last_q == LAST_RD));
    assign grant_r = ARVALID && (!AWVALID || (rr_last_q == LAST_WR));

    // Next-state logic, handshakes and the single SRAM access of this cycle.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        id_d      = id_q;
        len_d     = len_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rvalid_d  = rvalid_q;
        fresh_d   = 1'b0;
        hold_d    = fresh_q ? sram_do : hold_q;
        err_d     = err_q;
        bvalid_d  = bvalid_q;
        ar_rdy    = 1'b0;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        ceb       = 1'b1;
        web       = '1;
        a         = '0;
        di        = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_w) begin
                    aw_rdy    = 1'b1;
                    state_d   = S_WR;
                    rr_last_d = LAST_WR;
                    id_d      = AWID;
                    len_d     = AWLEN;
                    addr_d    = aw_word;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                end else if (grant_r) begin
                    ar_rdy    = 1'b1;
                    state_d   = S_RD;
                    rr_last_d = LAST_RD;
                    id_d      = ARID;
                    len_d     = ARLEN;
                    cnt_d     = '0;
                    ceb       = 1'b0;
                    a         = ar_word;
                    addr_d    = ar_word + ADDR_W'(1);
                    rvalid_d  = 1'b1;
                    fresh_d   = 1'b1;
                end
            end
            S_RD: begin
                if (rvalid_q && RREADY) begin
                    if (beat_last) begin
                        rvalid_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        // Fetch the following beat now so it is on RDATA next cycle.
                        ceb     = 1'b0;
                        a       = addr_q;
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = cnt_q + CNT_W'(1);
                        fresh_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                w_rdy = 1'b1;
                if (WVALID) begin
                    ceb    = 1'b0;
                    web    = ~WSTRB;
                    a      = addr_q;
                    di     = WDATA;
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (WLAST != beat_last) begin
                        err_d = 1'b1;
                    end
                    if (beat_last) begin
                        state_d  = S_WRESP;
                        bvalid_d = 1'b1;
                    end
                end
            end
            S_WRESP: begin
                if (BREADY) begin
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset must silence the combinational handshakes and the SRAM at once.
        if (!axi_rstn) begin
            ar_rdy = 1'b0;
            aw_rdy = 1'b0;
            w_rdy  = 1'b0;
            ceb    = 1'b1;
            web    = '1;
            a      = '0;
            di     = '0;
        end
    end

    // State and burst registers; reset aborts any burst in progress.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q   <= S_IDLE;
            rr_last_q <= LAST_RD;
            id_q      <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            fresh_q   <= 1'b0;
            hold_q    <= '0;
            err_q     <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            id_q      <= id_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            fresh_q   <= fresh_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
            bvalid_q  <= bvalid_d;
        end
    end

    assign ARREADY  = ar_rdy;
    assign AWREADY  = aw_rdy;
    assign WREADY   = w_rdy;
    assign RVALID   = rvalid_q;
    assign RID      = id_q;
    assign RDATA    = fresh_q ? sram_do : hold_q;
    assign RLAST    = rvalid_q && beat_last;
    assign RRESP    = 2'b00;
    assign BVALID   = bvalid_q;
    assign BID      = id_q;
    assign BRESP    = bvalid_q ? {err_q, 1'b0} : 2'b00;
    assign sram_ceb = ceb;
    assign sram_web = web;
    assign sram_a   = a;
    assign sram_di  = di;

endmodule

// File: tb/tb_axi_sram_slave_if.sv
// Bench for axi_sram_slave_if. It has an SRAM model, a reference memory and a
// scoreboard of expected R beats and B responses.
module tb_axi_sram_slave_if;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              axi_clk = 1'b0;
    logic              axi_rstn = 1'b0;
    logic [ID_W-1:0]   ARID = '0, AWID = '0, RID, BID;
    logic [31:0]       ARADDR = '0, AWADDR = '0;
    logic [LEN_W-1:0]  ARLEN = '0, AWLEN = '0;
    logic [2:0]        ARSIZE = 3'd2, AWSIZE = 3'd2;
    logic [1:0]        ARBURST = 2'b01, AWBURST = 2'b01;
    logic              ARVALID = 1'b0, AWVALID = 1'b0, ARREADY, AWREADY;
    logic [DATA_W-1:0] RDATA, WDATA = '0;
    logic [1:0]        RRESP, BRESP;
    logic              RLAST, RVALID, RREADY = 1'b0;
    logic [3:0]        WSTRB = '0;
    logic              WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic              BVALID, BREADY = 1'b0;
    logic              sram_ceb;
    logic [3:0]        sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_di;
    logic [DATA_W-1:0] sram_do = '0;

    axi_sram_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .axi_clk(axi_clk), .axi_rstn(axi_rstn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_di(sram_di),
        .sram_do(sram_do)
    );

    always #5 axi_clk = ~axi_clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEADBEEF;
        return (i * 32'h9E3779B1) + 32'h01234567;
    endfunction

    // SRAM model: one access per clock, read data one cycle later
    logic [31:0] mem [0:DEPTH-1];
    bit          mem_loaded = 1'b0;
    always @(posedge axi_clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (!sram_ceb) begin
            if (&sram_web) sram_do <= mem[sram_a];
            else for (int b = 0; b < 4; b++)
                if (!sram_web[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
        end
    end

    // reference memory and scoreboard
    logic [31:0] ref_mem [0:DEPTH-1];
    typedef struct { logic [31:0] data; logic [7:0] id; logic last; } rexp_t;
    typedef struct { logic [7:0] id; logic [1:0] resp; } bexp_t;
    rexp_t rq[$];
    bexp_t bq[$];

    logic [31:0] w_data [0:15];
    logic [3:0]  w_strb [0:15];
    logic        w_last [0:15];
    time         ar_t, aw_t;

    // monitor: pops expectations on each handshake and checks channel rules
    logic [31:0] pr_data;
    logic [7:0]  pr_id, pb_id;
    logic        pr_last, pr_stall = 1'b0, pb_stall = 1'b0;
    always @(negedge axi_clk) begin
        if (!axi_rstn) begin
            pr_stall <= 1'b0;
            pb_stall <= 1'b0;
        end else begin
            if (ARVALID && AWVALID)
                check(!(ARREADY && AWREADY), "both_ready", 64'({ARREADY, AWREADY}), 64'(2'b01));
            if (pr_stall && RVALID)
                check(RDATA === pr_data && RID === pr_id && RLAST === pr_last,
                      "r_stall_stable", 64'(RDATA), 64'(pr_data));
            if (RVALID && !RREADY)
                check(sram_ceb === 1'b1, "ceb_during_stall", 64'(sram_ceb), 64'd1);
            if (RVALID && RREADY) begin
                if (rq.size() == 0) begin
                    check(1'b0, "r_unexpected_beat", 64'(RDATA), 64'd0);
                end else begin
                    check(RDATA === rq[0].data, "r_data", 64'(RDATA), 64'(rq[0].data));
                    check(RID === rq[0].id, "r_id", 64'(RID), 64'(rq[0].id));
                    check(RLAST === rq[0].last, "r_last", 64'(RLAST), 64'(rq[0].last));
                    check(RRESP === 2'b00, "r_resp", 64'(RRESP), 64'd0);
                    void'(rq.pop_front());
                end
            end
            if (pb_stall)
                check(BVALID === 1'b1 && BID === pb_id, "b_stable", 64'(BID), 64'(pb_id));
            if (BVALID && BREADY) begin
                if (bq.size() == 0) begin
                    check(1'b0, "b_unexpected", 64'(BRESP), 64'd0);
                end else begin
                    check(BID === bq[0].id, "b_id", 64'(BID), 64'(bq[0].id));
                    check(BRESP === bq[0].resp, "b_resp", 64'(BRESP), 64'(bq[0].resp));
                    void'(bq.pop_front());
                end
            end
            pr_stall <= RVALID && !RREADY;
            pr_data  <= RDATA;
            pr_id    <= RID;
            pr_last  <= RLAST;
            pb_stall <= BVALID && !BREADY;
            pb_id    <= BID;
        end
    end

    task automatic ar_hs(input logic [7:0] id, input logic [31:0] addr, input int len);
        bit ok = 1'b0;
        @(posedge axi_clk); #1;
        ARID = id; ARADDR = addr; ARLEN = 4'(len); ARVALID = 1'b1;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge axi_clk);
            if (ARREADY) ok = 1'b1;
        end
        @(posedge axi_clk); ar_t = $time; #1;
        ARVALID = 1'b0;
        check(ok, "ar_accept", 64'(ok), 64'd1);
    endtask

    task automatic aw_hs(input logic [7:0] id, input logic [31:0] addr, input int len);
        bit ok = 1'b0;
        @(posedge axi_clk); #1;
        AWID = id; AWADDR = addr; AWLEN = 4'(len); AWVALID = 1'b1;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge axi_clk);
            if (AWREADY) ok = 1'b1;
        end
        @(posedge axi_clk); aw_t = $time; #1;
        AWVALID = 1'b0;
        check(ok, "aw_accept", 64'(ok), 64'd1);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int stall_beat, input int stall_n);
        int base = int'(addr[ADDR_W+1:2]);
        int beat = 0;
        int stalled = 0;
        for (int i = 0; i <= len; i++)
            rq.push_back('{ref_mem[(base + i) % DEPTH], id, (i == len)});
        ar_hs(id, addr, len);
        check(RVALID === 1'b1, "r_first_latency", 64'(RVALID), 64'd1);
        for (int c = 0; c < len + stall_n + 40 && beat <= len; c++) begin
            if (RVALID && beat == stall_beat && stalled < stall_n) begin
                RREADY = 1'b0;
                stalled++;
            end else begin
                RREADY = 1'b1;
            end
            @(negedge axi_clk);
            if (RVALID && RREADY) beat++;
            @(posedge axi_clk); #1;
        end
        RREADY = 1'b0;
        check(beat == len + 1, "r_burst_beats", 64'(beat), 64'(len + 1));
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input int gap_max, input int bdelay);
        int base = int'(addr[ADDR_W+1:2]);
        logic [1:0] resp = 2'b00;
        bit ok;
        for (int i = 0; i <= len; i++) begin
            if (w_last[i] != (i == len)) resp = 2'b10;
            for (int b = 0; b < 4; b++)
                if (w_strb[i][b]) ref_mem[(base + i) % DEPTH][8*b +: 8] = w_data[i][8*b +: 8];
        end
        bq.push_back('{id, resp});
        aw_hs(id, addr, len);
        for (int i = 0; i <= len; i++) begin
            int gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            WVALID = 1'b0;
            repeat (gap) begin @(posedge axi_clk); #1; end
            WVALID = 1'b1; WDATA = w_data[i]; WSTRB = w_strb[i]; WLAST = w_last[i];
            ok = 1'b0;
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge axi_clk);
                if (WREADY) ok = 1'b1;
            end
            @(posedge axi_clk); #1;
            check(ok, "w_accept", 64'(ok), 64'd1);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check(BVALID === 1'b1, "b_latency", 64'(BVALID), 64'd1);
        repeat (bdelay) begin @(posedge axi_clk); #1; end
        BREADY = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge axi_clk);
            if (BVALID) ok = 1'b1;
        end
        @(posedge axi_clk); #1;
        BREADY = 1'b0;
        check(ok, "b_handshake", 64'(ok), 64'd1);
    endtask

    task automatic set_wbeats(input int len, input bit rnd_strb);
        for (int i = 0; i < 16; i++) begin
            w_data[i] = $urandom;
            w_strb[i] = rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF;
            w_last[i] = (i == len);
        end
    endtask

    initial begin
        int beat;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        // reset state, with both address valids pushed to provoke a ready
        ARVALID = 1'b1; AWVALID = 1'b1;
        repeat (3) @(posedge axi_clk);
        #1;
        check(ARREADY === 1'b0 && AWREADY === 1'b0, "rst_readies", 64'({ARREADY, AWREADY}), 64'd0);
        check(RVALID === 1'b0 && BVALID === 1'b0 && RLAST === 1'b0 && WREADY === 1'b0,
              "rst_valids", 64'({RVALID, BVALID, RLAST, WREADY}), 64'd0);
        check(RDATA === '0 && RID === '0 && BID === '0 && BRESP === 2'b00 && RRESP === 2'b00,
              "rst_data", 64'(RDATA), 64'd0);
        check(sram_ceb === 1'b1 && sram_web === 4'hF && sram_a === '0 && sram_di === '0,
              "rst_sram", 64'({sram_ceb, sram_web}), 64'h1F);
        ARVALID = 1'b0; AWVALID = 1'b0;
        @(negedge axi_clk); axi_rstn = 1'b1;

        // single read, then a burst read with a two-cycle stall on beat 1
        do_read(8'h13, 32'h40, 0, -1, 0);
        do_read(8'h22, 32'h100, 3, 1, 2);

        // burst write with mixed strobes, read back
        set_wbeats(3, 1'b0);
        w_strb[0] = 4'hF; w_strb[1] = 4'h1; w_strb[2] = 4'h0; w_strb[3] = 4'hC;
        do_write(8'h5A, 32'h200, 3, 0, 0);
        do_read(8'h5B, 32'h200, 3, -1, 0);

        // simultaneous AR/AW, twice: write wins each time (READ then READ last)
        for (int k = 0; k < 2; k++) begin
            set_wbeats(1, 1'b1);
            fork
                do_write(8'hA1, 32'h300 + 32'(k * 64), 1, 0, 0);
                do_read(8'hA2, 32'h400 + 32'(k * 64), 2, -1, 0);
            join
            check(aw_t < ar_t, "arb_write_first", 64'(aw_t), 64'(ar_t));
        end

        // early WLAST: both beats still written, SLVERR
        set_wbeats(1, 1'b0);
        w_last[0] = 1'b1; w_last[1] = 1'b0;
        do_write(8'h3C, 32'h600, 1, 0, 1);
        do_read(8'h3D, 32'h600, 1, -1, 0);
        // address wrap at the top of the SRAM
        do_read(8'h3E, 32'hFFFC, 1, -1, 0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int len = int'($urandom_range(0, 15));
            logic [31:0] addr = $urandom;
            logic [7:0] id = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                set_wbeats(len, 1'b1);
                if ($urandom_range(0, 3) == 0) begin
                    int j = int'($urandom_range(0, len));
                    w_last[j] = ~w_last[j];
                end
                do_write(id, addr, len, 2, int'($urandom_range(0, 3)));
            end else begin
                do_read(id, addr, len, int'($urandom_range(0, len)), int'($urandom_range(0, 3)));
            end
        end

        // reset during beat 2 of a len=7 read
        for (int i = 0; i <= 7; i++) rq.push_back('{ref_mem[(512 + i) % DEPTH], 8'h66, (i == 7)});
        ar_hs(8'h66, 32'h800, 7);
        RREADY = 1'b1;
        beat = 0;
        for (int c = 0; c < 40 && beat < 2; c++) begin
            @(negedge axi_clk);
            if (RVALID && RREADY) beat++;
        end
        @(posedge axi_clk); #2;
        axi_rstn = 1'b0;
        #1;
        check(RVALID === 1'b0 && RLAST === 1'b0 && RDATA === '0 && RID === '0,
              "midrst_r", 64'(RDATA), 64'd0);
        check(sram_ceb === 1'b1 && sram_web === 4'hF, "midrst_ceb", 64'({sram_ceb, sram_web}), 64'h1F);
        check(ARREADY === 1'b0 && AWREADY === 1'b0 && WREADY === 1'b0 && BVALID === 1'b0,
              "midrst_ctrl", 64'({ARREADY, AWREADY, WREADY, BVALID}), 64'd0);
        rq.delete();
        RREADY = 1'b0;
        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk); axi_rstn = 1'b1;
        do_read(8'h77, 32'h840, 2, -1, 0);

        repeat (3) @(posedge axi_clk);
        check(rq.size() == 0, "r_queue_drained", 64'(rq.size()), 64'd0);
        check(bq.size() == 0, "b_queue_drained", 64'(bq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
